// File: rtl/memory_access_stage.sv
// memory_access_stage: MEM stage of the 5-stage MIPS pipeline.
// Issues loads/stores on a registered req/ack data-memory port, holds the
// MEM/WB pipeline register and raises MemStall while an access is pending.
// Optional feature: define MEM_TIMEOUT_EN to abort a WAIT that exceeds
// TIMEOUT cycles and flag it on the sticky MemTimeoutErr output.
module memory_access_stage #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned REG_AW  = 5,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ExMemValid,
  input  logic [DATA_W-1:0] ExMemAluOutput,
  input  logic [DATA_W-1:0] ExMemWriteData,
  input  logic [REG_AW-1:0] ExMemDestination,
  input  logic              ExMemMemRead,
  input  logic              ExMemMemWrite,
  input  logic              ExMemWriteRegEnable,
  input  logic              ExMemwritebackRegCtrl,
  output logic              DmemReq,
  output logic              DmemWe,
  output logic [DATA_W-1:0] DmemAddr,
  output logic [DATA_W-1:0] DmemWdata,
  input  logic              DmemAck,
  input  logic [DATA_W-1:0] DmemRdata,
  output logic              MemStall,
  output logic              MemAlignErr,
`ifdef MEM_TIMEOUT_EN
  output logic              MemTimeoutErr,
`endif
  output logic [DATA_W-1:0] MemWbAluOutput,
  output logic [DATA_W-1:0] MemWbMemoryReadData,
  output logic [REG_AW-1:0] MemWbDestination_Rt_RdOutput,
  output logic              MemWbWriteRegEnable,
  output logic              MemWbwritebackRegCtrl
);

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } state_t;

  state_t              state_q, state_d;

  // captured access (drives the memory port while waiting)
  logic                req_q, req_d;
  logic                we_q, we_d;
  logic [DATA_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [REG_AW-1:0]   dest_q, dest_d;
  logic                wre_q, wre_d;
  logic                ctrl_q, ctrl_d;

  // MEM/WB pipeline register
  logic [DATA_W-1:0]   mw_alu_q, mw_alu_d;
  logic [DATA_W-1:0]   mw_rdata_q, mw_rdata_d;
  logic [REG_AW-1:0]   mw_dest_q, mw_dest_d;
  logic                mw_wre_q, mw_wre_d;
  logic                mw_ctrl_q, mw_ctrl_d;

  logic                align_err_q, align_err_d;

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                tmo_err_q, tmo_err_d;
`endif

  logic                memop;
  logic                aligned;

  assign memop   = ExMemValid & (ExMemMemRead | ExMemMemWrite);
  assign aligned = (ExMemAluOutput[1:0] == 2'b00);

  // Next-state, capture and MEM/WB update; MEM/WB defaults to a bubble that
  // keeps its data fields and clears only the write enable.
  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    dest_d      = dest_q;
    wre_d       = wre_q;
    ctrl_d      = ctrl_q;
    mw_alu_d    = mw_alu_q;
    mw_rdata_d  = mw_rdata_q;
    mw_dest_d   = mw_dest_q;
    mw_wre_d    = 1'b0;
    mw_ctrl_d   = mw_ctrl_q;
    align_err_d = align_err_q;
    MemStall    = 1'b0;
`ifdef MEM_TIMEOUT_EN
    cnt_d       = '0;
    tmo_err_d   = tmo_err_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (ExMemValid && !memop) begin
          mw_alu_d   = ExMemAluOutput;
          mw_rdata_d = '0;
          mw_dest_d  = ExMemDestination;
          mw_wre_d   = ExMemWriteRegEnable;
          mw_ctrl_d  = ExMemwritebackRegCtrl;
        end else if (memop && aligned) begin
          MemStall = 1'b1;
          req_d    = 1'b1;
          // read+write together is illegal and handled as a load
          we_d     = ExMemMemWrite & ~ExMemMemRead;
          addr_d   = ExMemAluOutput;
          wdata_d  = ExMemWriteData;
          dest_d   = ExMemDestination;
          wre_d    = ExMemWriteRegEnable;
          ctrl_d   = ExMemwritebackRegCtrl;
          state_d  = S_WAIT;
        end else if (memop) begin
          align_err_d = 1'b1;
        end
      end

      S_WAIT: begin
        MemStall = ~DmemAck;
        if (DmemAck) begin
          mw_alu_d   = addr_q;
          mw_rdata_d = DmemRdata;
          mw_dest_d  = dest_q;
          mw_wre_d   = wre_q & ~we_q;
          mw_ctrl_d  = ctrl_q;
          req_d      = 1'b0;
          state_d    = S_IDLE;
        end
`ifdef MEM_TIMEOUT_EN
        // aborting releases the stall in the same cycle so upstream drops
        // the stuck instruction instead of re-issuing it from IDLE
        else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          MemStall  = 1'b0;
          req_d     = 1'b0;
          tmo_err_d = 1'b1;
          state_d   = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers, asynchronously cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      dest_q      <= '0;
      wre_q       <= 1'b0;
      ctrl_q      <= 1'b0;
      mw_alu_q    <= '0;
      mw_rdata_q  <= '0;
      mw_dest_q   <= '0;
      mw_wre_q    <= 1'b0;
      mw_ctrl_q   <= 1'b0;
      align_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      dest_q      <= dest_d;
      wre_q       <= wre_d;
      ctrl_q      <= ctrl_d;
      mw_alu_q    <= mw_alu_d;
      mw_rdata_q  <= mw_rdata_d;
      mw_dest_q   <= mw_dest_d;
      mw_wre_q    <= mw_wre_d;
      mw_ctrl_q   <= mw_ctrl_d;
      align_err_q <= align_err_d;
    end
  end

`ifdef MEM_TIMEOUT_EN
  // Wait-cycle counter and sticky timeout flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      tmo_err_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      tmo_err_q <= tmo_err_d;
    end
  end

  assign MemTimeoutErr = tmo_err_q;
`endif

  assign DmemReq                      = req_q;
  assign DmemWe                       = we_q;
  assign DmemAddr                     = addr_q;
  assign DmemWdata                    = wdata_q;
  assign MemAlignErr                  = align_err_q;
  assign MemWbAluOutput               = mw_alu_q;
  assign MemWbMemoryReadData          = mw_rdata_q;
  assign MemWbDestination_Rt_RdOutput = mw_dest_q;
  assign MemWbWriteRegEnable          = mw_wre_q;
  assign MemWbwritebackRegCtrl        = mw_ctrl_q;

endmodule
